// File: rtl/conv_mac_tree_if.sv
// Handshake bundle for conv_mac_tree: serial kernel load port, window input
// stream and result output stream. The master drives windows and coefficients.
interface conv_mac_tree_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int K      = 3,
  parameter int ACC_W  = 20
);
  logic                  kern_start;
  logic                  kern_wr;
  logic [COEF_W-1:0]     kern_din;
  logic                  kern_loaded;
  logic                  win_valid;
  logic                  win_ready;
  logic [K*K*DATA_W-1:0] win_data;
  logic                  res_valid;
  logic                  res_ready;
  logic [ACC_W-1:0]      res_data;

  modport master (
    output kern_start, kern_wr, kern_din, win_valid, win_data, res_ready,
    input  kern_loaded, win_ready, res_valid, res_data
  );

  modport slave (
    input  kern_start, kern_wr, kern_din, win_valid, win_data, res_ready,
    output kern_loaded, win_ready, res_valid, res_data
  );
endinterface

// File: rtl/conv_mac_tree.sv
// Pipelined KxK convolution MAC: signed coefficients x unsigned pixels, registered
// binary adder tree, double-buffered kernel. Define CONV_MAC_TREE_RELU_EN for ReLU output.
module conv_mac_tree #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int K      = 3,
  parameter int ACC_W  = 20
) (
  input logic            clk,
  input logic            rst,
  conv_mac_tree_if.slave bus
);
  localparam int N      = K * K;
  localparam int STAGES = $clog2(N);
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;

  function automatic int cnt_f(input int lvl);
    int c;
    c = N;
    for (int m = 0; m < lvl; m++) c = (c + 1) / 2;
    return c;
  endfunction

  function automatic int off_f(input int lvl);
    int o;
    o = 0;
    for (int m = 0; m < lvl; m++) o += cnt_f(m);
    return o;
  endfunction

  // Tree nodes are stored flat, level by level; the last node is the result.
  localparam int NODES = off_f(STAGES + 1);
  localparam int LAST  = NODES - 1;

  function automatic logic signed [ACC_W-1:0] mul_f(input logic signed [COEF_W-1:0] c,
                                                    input logic [DATA_W-1:0] p);
    logic signed [ACC_W-1:0] ce;
    logic signed [ACC_W-1:0] pe;
    ce = ACC_W'(c);
    pe = $signed(ACC_W'(p));
    return ce * pe;
  endfunction

  function automatic logic signed [ACC_W-1:0] fin_f(input logic signed [ACC_W-1:0] s);
`ifdef CONV_MAC_TREE_RELU_EN
    return s[ACC_W-1] ? '0 : s;
`else
    return s;
`endif
  endfunction

  logic signed [COEF_W-1:0] shadow [N];
  logic signed [COEF_W-1:0] active [N];
  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         wr_idx;
  logic                     commit;
  logic                     loaded;

  assign wr_idx = bus.kern_start ? '0 : idx;
  assign commit = bus.kern_wr && (wr_idx == IDX_W'(N - 1));

  // Coefficients land flipped so active[i] multiplies pixel i directly; the
  // committing write bypasses the shadow bank into active[0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      loaded <= 1'b0;
      for (int i = 0; i < N; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (bus.kern_wr) begin
        shadow[N - 1 - int'(wr_idx)] <= bus.kern_din;
        idx <= commit ? '0 : wr_idx + 1'b1;
      end else if (bus.kern_start) begin
        idx <= '0;
      end
      if (commit) begin
        for (int i = 1; i < N; i++) active[i] <= shadow[i];
        active[0] <= bus.kern_din;
        loaded    <= 1'b1;
      end
    end
  end

  logic                    en;
  logic                    take;
  logic [STAGES:0]         vld_p;
  logic signed [ACC_W-1:0] tree_p   [NODES];
  logic signed [ACC_W-1:0] tree_nxt [NODES];

  assign en   = !vld_p[STAGES] || bus.res_ready;
  assign take = bus.win_valid && loaded;

  // Stage 0: one product per tap
  for (genvar i = 0; i < N; i++) begin : g_prod
    assign tree_nxt[i] = mul_f(active[i], bus.win_data[i*DATA_W +: DATA_W]);
  end

  // Stages 1..STAGES: pairwise sums, odd leftover passed through
  for (genvar l = 1; l <= STAGES; l++) begin : g_lvl
    localparam int CI = cnt_f(l - 1);
    localparam int CO = cnt_f(l);
    localparam int OI = off_f(l - 1);
    localparam int OO = off_f(l);
    for (genvar j = 0; j < CO; j++) begin : g_node
      if (2 * j + 1 < CI) begin : g_add
        assign tree_nxt[OO + j] = tree_p[OI + 2*j] + tree_p[OI + 2*j + 1];
      end else begin : g_pass
        assign tree_nxt[OO + j] = tree_p[OI + 2*j];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
      for (int n = 0; n < NODES; n++) tree_p[n] <= '0;
    end else if (en) begin
      vld_p[0] <= take;
      for (int s = 1; s <= STAGES; s++) vld_p[s] <= vld_p[s-1];
      for (int n = 0; n < LAST; n++) tree_p[n] <= tree_nxt[n];
      tree_p[LAST] <= fin_f(tree_nxt[LAST]);
    end
  end

  assign bus.win_ready   = en && loaded;
  assign bus.kern_loaded = loaded;
  assign bus.res_valid   = vld_p[STAGES];
  assign bus.res_data    = tree_p[LAST];
endmodule

// File: tb/tb_conv_mac_tree.sv
// Self-checking bench for conv_mac_tree: directed vector table, burst/stall,
// kernel swap, mid-stream reset, and a randomized run against a reference model.
module tb_conv_mac_tree;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int K      = 3;
  localparam int ACC_W  = 20;
  localparam int N      = K * K;
  localparam int LAT    = 1 + $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_mac_tree_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .K(K), .ACC_W(ACC_W)) bus ();

  conv_mac_tree #(.DATA_W(DATA_W), .COEF_W(COEF_W), .K(K), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef logic [N-1:0][COEF_W-1:0] kern_t;
  typedef logic [N-1:0][DATA_W-1:0] pix_t;

  typedef struct {
    string  name;
    kern_t  k;
    pix_t   p;
    longint exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint relu_exp(input longint v);
`ifdef CONV_MAC_TREE_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Reference model: kernel kept in the order written (k0..k(N-1)).
  logic signed [COEF_W-1:0] m_raw [N];
  logic signed [COEF_W-1:0] m_act [N];
  int     m_idx    = 0;
  bit     m_loaded = 0;
  longint exp_q [$];
  longint got_q [$];
  int     res_cnt  = 0;
  bit     stall_prev = 0;
  longint stall_data = 0;

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_raw[i] = '0;
      m_act[i] = '0;
    end
    m_idx = 0;
    m_loaded = 0;
    exp_q.delete();
  endtask

  function automatic longint ref_conv(input pix_t px);
    longint s;
    s = 0;
    for (int i = 0; i < N; i++)
      s += longint'(m_act[N-1-i]) * longint'(px[i]);
    return relu_exp(s);
  endfunction

  always @(negedge clk) begin : mon
    longint sdata;
    longint e;
    int w;
    if (!rst) begin
      sdata = longint'($signed(bus.res_data));
      if (stall_prev) begin
        chk("stall_valid", longint'(bus.res_valid), 1);
        chk("stall_data", sdata, stall_data);
      end
      chk("win_ready", longint'(bus.win_ready),
          longint'(m_loaded && (!bus.res_valid || bus.res_ready)));
      chk("kern_loaded", longint'(bus.kern_loaded), longint'(m_loaded));
      if (bus.res_valid && bus.res_ready) begin
        res_cnt++;
        got_q.push_back(sdata);
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("res_data", sdata, e);
        end
      end
      if (bus.win_valid && bus.win_ready) exp_q.push_back(ref_conv(bus.win_data));
      if (bus.kern_wr) begin
        w = bus.kern_start ? 0 : m_idx;
        m_raw[w] = bus.kern_din;
        if (w == N - 1) begin
          m_act = m_raw;
          m_loaded = 1;
        end
        m_idx = (w + 1) % N;
      end else if (bus.kern_start) begin
        m_idx = 0;
      end
      stall_prev = bus.res_valid && !bus.res_ready;
      stall_data = sdata;
    end else begin
      stall_prev = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_kernel(input kern_t k);
    for (int i = 0; i < N; i++) begin
      bus.kern_wr    = 1'b1;
      bus.kern_start = (i == 0);
      bus.kern_din   = k[i];
      tick();
    end
    bus.kern_wr    = 1'b0;
    bus.kern_start = 1'b0;
  endtask

  function automatic pix_t pat(input int w, input int mode);
    pix_t p;
    for (int i = 0; i < N; i++) p[i] = (mode == 0) ? DATA_W'(w + 1) : DATA_W'(1);
    return p;
  endfunction

  function automatic kern_t kconst(input int v);
    kern_t k;
    for (int i = 0; i < N; i++) k[i] = COEF_W'(v);
    return k;
  endfunction

  task automatic stream(input int n, input int mode);
    int w;
    int guard;
    bit acc;
    w = 0;
    guard = 0;
    bus.win_valid = 1'b1;
    bus.win_data  = pat(0, mode);
    while (w < n && guard < 200) begin
      @(negedge clk);
      acc = bus.win_ready;
      tick();
      guard++;
      if (acc) begin
        w++;
        if (w < n) bus.win_data = pat(w, mode);
      end
    end
    bus.win_valid = 1'b0;
    chk("stream_done", w, n);
  endtask

  task automatic wait_drain(input int limit);
    for (int c = 0; c < limit && exp_q.size() != 0; c++) tick();
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    bit seen;
    load_kernel(v.k);
    bus.win_data  = v.p;
    bus.win_valid = 1'b1;
    seen = 0;
    for (int g = 0; g < 10 && !seen; g++) begin
      @(negedge clk);
      seen = bus.win_ready;
      if (!seen) tick();
    end
    tick();
    bus.win_valid = 1'b0;
    chk({v.name, "_accept"}, longint'(seen), 1);
    // latency counted from the accept cycle to the first cycle with res_valid
    lat = 0;
    seen = 0;
    for (int g = 0; g < 20 && !seen; g++) begin
      @(negedge clk);
      lat++;
      seen = bus.res_valid;
    end
    chk({v.name, "_latency"}, lat, LAT);
    chk({v.name, "_data"}, longint'($signed(bus.res_data)), v.exp);
    tick();
  endtask

  vec_t tbl [7];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin : main
    int rc0;
    int trans;
    pix_t rp;
    kern_t kk;

    bus.kern_start = 1'b0;
    bus.kern_wr    = 1'b0;
    bus.kern_din   = '0;
    bus.win_valid  = 1'b0;
    bus.win_data   = '0;
    bus.res_ready  = 1'b1;
    m_reset();

    tbl[0].name = "basic";
    tbl[0].k = kconst(1);
    for (int i = 0; i < N; i++) tbl[0].p[i] = DATA_W'(i + 1);
    tbl[0].exp = 45;
    tbl[1].name = "flip_k0";
    tbl[1].k = kconst(0);
    tbl[1].k[0] = COEF_W'(1);
    for (int i = 0; i < N; i++) tbl[1].p[i] = DATA_W'(10 + i);
    tbl[1].exp = 18;
    tbl[2].name = "flip_k8";
    tbl[2].k = kconst(0);
    tbl[2].k[N-1] = COEF_W'(1);
    tbl[2].p = tbl[1].p;
    tbl[2].exp = 10;
    tbl[3].name = "signed_min1";
    tbl[3].k = kconst(-1);
    for (int i = 0; i < N; i++) tbl[3].p[i] = DATA_W'(255);
    tbl[3].exp = relu_exp(-2295);
    tbl[4].name = "mixed";
    for (int i = 0; i < N; i++) begin
      tbl[4].k[i] = COEF_W'(i - 4);
      tbl[4].p[i] = DATA_W'(20 * i);
    end
    tbl[4].exp = relu_exp(-1200);
    tbl[5].name = "max_pos";
    tbl[5].k = kconst(127);
    tbl[5].p = tbl[3].p;
    tbl[5].exp = 291465;
    tbl[6].name = "max_neg";
    tbl[6].k = kconst(-128);
    tbl[6].p = tbl[3].p;
    tbl[6].exp = relu_exp(-293760);

    // reset state
    @(posedge clk);
    #1;
    chk("rst_res_valid", longint'(bus.res_valid), 0);
    chk("rst_res_data", longint'(bus.res_data), 0);
    chk("rst_kern_loaded", longint'(bus.kern_loaded), 0);
    chk("rst_win_ready", longint'(bus.win_ready), 0);
    tick();
    rst = 1'b0;
    bus.win_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.res_ready = c[0];
      tick();
      chk("preload_win_ready", longint'(bus.win_ready), 0);
    end
    bus.win_valid = 1'b0;
    bus.res_ready = 1'b1;

    for (int t = 0; t < 7; t++) run_vec(tbl[t]);

    // back-to-back burst with a 3-cycle downstream stall
    for (int i = 0; i < N; i++) kk[i] = COEF_W'(i + 1);
    load_kernel(kk);
    got_q.delete();
    rc0 = res_cnt;
    fork
      stream(8, 0);
      begin
        repeat (6) tick();
        bus.res_ready = 1'b0;
        repeat (3) tick();
        bus.res_ready = 1'b1;
      end
    join
    wait_drain(40);
    chk("burst_count", res_cnt - rc0, 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) chk("burst_order", got_q[i], 45 * (i + 1));

    // kernel swap from all-1 to all-2 while windows stream
    load_kernel(kconst(1));
    got_q.delete();
    fork
      stream(25, 1);
      begin
        repeat (6) tick();
        load_kernel(kconst(2));
      end
    join
    wait_drain(40);
    chk("swap_count", got_q.size(), 25);
    if (got_q.size() == 25) begin
      chk("swap_first", got_q[0], 9);
      chk("swap_last", got_q[24], 18);
      trans = 0;
      for (int i = 1; i < 25; i++) if (got_q[i] != got_q[i-1]) trans++;
      chk("swap_transitions", trans, 1);
    end

    // asynchronous reset with three windows in flight
    load_kernel(kconst(1));
    bus.win_data  = pat(4, 0);
    bus.win_valid = 1'b1;
    repeat (3) tick();
    bus.win_valid = 1'b0;
    tick();
    #1;
    rst = 1'b1;
    #1;
    chk("arst_res_valid", longint'(bus.res_valid), 0);
    chk("arst_res_data", longint'(bus.res_data), 0);
    chk("arst_kern_loaded", longint'(bus.kern_loaded), 0);
    chk("arst_win_ready", longint'(bus.win_ready), 0);
    m_reset();
    tick();
    rst = 1'b0;
    rc0 = res_cnt;
    bus.win_valid = 1'b1;
    repeat (10) tick();
    chk("no_stale", res_cnt - rc0, 0);
    for (int i = 0; i < 4; i++) begin
      bus.kern_wr    = 1'b1;
      bus.kern_start = (i == 0);
      bus.kern_din   = COEF_W'(3);
      tick();
    end
    bus.kern_wr    = 1'b0;
    bus.kern_start = 1'b0;
    tick();
    chk("partial_kern_loaded", longint'(bus.kern_loaded), 0);
    chk("partial_win_ready", longint'(bus.win_ready), 0);
    bus.win_valid = 1'b0;
    run_vec(tbl[0]);

    // randomized traffic with kernel rewrites and back-pressure
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) rp[i] = DATA_W'($urandom);
      bus.win_data   = rp;
      bus.win_valid  = ($urandom_range(3) != 0);
      bus.res_ready  = ($urandom_range(3) != 0);
      bus.kern_wr    = ($urandom_range(5) == 0);
      bus.kern_start = ($urandom_range(19) == 0);
      bus.kern_din   = COEF_W'($urandom);
      tick();
    end
    bus.win_valid  = 1'b0;
    bus.kern_wr    = 1'b0;
    bus.kern_start = 1'b0;
    bus.res_ready  = 1'b1;
    wait_drain(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
